bullet_ctrl: RTL and testbench



---
 rtl/bullet_pkg.sv | 12 +
 rtl/bullet_axis.sv | 42 ++++
 rtl/bullet_ctrl.sv | 62 ++++++
 tb/tb_bullet_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// bullet_pkg: shared playfield bounds, coordinate widths and bullet FSM states
package bullet_pkg;
  localparam int X_MIN = 2;
  localparam int X_MAX = 762;
  localparam int Y_MIN = 36;
  localparam int Y_MAX = 562;
  localparam int BR = 12;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int VW = 4;
  typedef enum logic [1:0] {FROZEN, RUN, DEAD} state_t;
endpackage

// File: rtl/bullet_axis.sv
// bullet_axis: one-axis position/velocity register with clamp-bounce and saturating speed-up
module bullet_axis
  import bullet_pkg::*;
#(
  parameter int W = 11,
  parameter int LO = 14,
  parameter int HI = 750,
  parameter int P0 = 200,
  parameter int V0 = 2,
  parameter int VMAX = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         speedup,
  output logic [W-1:0] pos
);
  localparam logic [11:0] LO_V = 12'(LO);
  localparam logic [11:0] HI_V = 12'(HI);
  localparam logic [VW-1:0] VMAX_V = VW'(VMAX);
  logic [VW-1:0] vel, mag, mag_up;
  logic [11:0] nxt;
  logic lo_hit, hi_hit, neg;
  always_comb begin
    nxt = {{(12-W){1'b0}}, pos} + {{(12-VW){vel[VW-1]}}, vel};
    lo_hit = $signed(nxt) < $signed(LO_V);
    hi_hit = !lo_hit && $signed(nxt) > $signed(HI_V);
    neg = lo_hit ? 1'b0 : hi_hit ? 1'b1 : vel[VW-1];
    mag = vel[VW-1] ? -vel : vel;
    mag_up = speedup && mag < VMAX_V ? mag + 1'b1 : mag;
  end
  always_ff @(posedge clk) begin
    if (rst || load) begin
      pos <= W'(P0);
      vel <= VW'(V0);
    end else if (step) begin
      pos <= lo_hit ? W'(LO) : hi_hit ? W'(HI) : nxt[W-1:0];
      vel <= neg ? -mag_up : mag_up;
    end
  end
endmodule

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: run/dead/frozen control, motion tick prescaler and speed-up for two enemy bullets
module bullet_ctrl
  import bullet_pkg::*;
#(
  parameter int TICK_DIV = 833333,
  parameter int SPEEDUP_TICKS = 600,
  parameter int B1_X0 = 200,
  parameter int B1_Y0 = 150,
  parameter int B2_X0 = 600,
  parameter int B2_Y0 = 450,
  parameter int V_INIT = 2,
  parameter int V_MAX = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frz,
  input  logic          over,
  output logic [XW-1:0] bullet1_x,
  output logic [YW-1:0] bullet1_y,
  output logic [XW-1:0] bullet2_x,
  output logic [YW-1:0] bullet2_y,
  output logic          tick,
  output logic          running
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SPEEDUP_TICKS + 1);
  logic [PW-1:0] pre;
  logic [SW-1:0] spd;
  state_t state, state_nxt;
  logic step, speedup;
  assign tick = pre == PW'(TICK_DIV - 1);
  assign step = state == RUN && !frz && !over && tick;
  assign speedup = step && spd == SW'(SPEEDUP_TICKS - 1);
  always_comb begin
    state_nxt = frz ? FROZEN : state == FROZEN ? RUN : state == RUN && over ? DEAD : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      spd <= '0;
      state <= FROZEN;
      running <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      spd <= frz || speedup ? '0 : step ? spd + 1'b1 : spd;
      state <= state_nxt;
      running <= state_nxt == RUN;
    end
  end
  bullet_axis #(.W(XW), .LO(X_MIN + BR), .HI(X_MAX - BR), .P0(B1_X0), .V0(V_INIT), .VMAX(V_MAX)) u_b1x (
    .clk(clk), .rst(rst), .load(frz), .step(step), .speedup(speedup), .pos(bullet1_x)
  );
  bullet_axis #(.W(YW), .LO(Y_MIN + BR), .HI(Y_MAX - BR), .P0(B1_Y0), .V0(V_INIT), .VMAX(V_MAX)) u_b1y (
    .clk(clk), .rst(rst), .load(frz), .step(step), .speedup(speedup), .pos(bullet1_y)
  );
  bullet_axis #(.W(XW), .LO(X_MIN + BR), .HI(X_MAX - BR), .P0(B2_X0), .V0(-V_INIT), .VMAX(V_MAX)) u_b2x (
    .clk(clk), .rst(rst), .load(frz), .step(step), .speedup(speedup), .pos(bullet2_x)
  );
  bullet_axis #(.W(YW), .LO(Y_MIN + BR), .HI(Y_MAX - BR), .P0(B2_Y0), .V0(V_INIT), .VMAX(V_MAX)) u_b2y (
    .clk(clk), .rst(rst), .load(frz), .step(step), .speedup(speedup), .pos(bullet2_y)
  );
endmodule

// File: tb/tb_bullet_ctrl.sv
// tb_bullet_ctrl: randomized and directed checks of bullet_ctrl against a behavioural model
module tb_bullet_ctrl;
  localparam int TD = 4;
  localparam int ST = 3;
  logic clk = 0, rst = 1, frz = 1, over = 0;
  logic [10:0] bullet1_x, bullet2_x;
  logic [9:0] bullet1_y, bullet2_y;
  logic tick, running;
  int checks = 0, errors = 0;
  bullet_ctrl #(.TICK_DIV(TD), .SPEEDUP_TICKS(ST)) dut (
    .clk(clk), .rst(rst), .frz(frz), .over(over),
    .bullet1_x(bullet1_x), .bullet1_y(bullet1_y), .bullet2_x(bullet2_x), .bullet2_y(bullet2_y),
    .tick(tick), .running(running)
  );
  always #5 clk = ~clk;
  int lo[4] = '{14, 48, 14, 48};
  int hi[4] = '{750, 550, 750, 550};
  int p0[4] = '{200, 150, 600, 450};
  int v0[4] = '{2, 2, -2, 2};
  int mp[4], mv[4];
  int ms = 0, mpre = 0, mspd = 0, clamps = 0;
  always @(posedge clk) begin
    bit t;
    int n, m;
    t = mpre == TD - 1;
    if (rst) begin
      mpre = 0; mspd = 0; ms = 0; mp = p0; mv = v0;
    end else begin
      mpre = (mpre + 1) % TD;
      if (frz) begin
        ms = 0; mspd = 0; mp = p0; mv = v0;
      end else if (ms == 0) ms = 1;
      else if (ms == 1 && over) ms = 2;
      else if (ms == 1 && t) begin
        mspd++;
        for (int i = 0; i < 4; i++) begin
          n = mp[i] + mv[i];
          m = mv[i] < 0 ? -mv[i] : mv[i];
          if (n < lo[i]) begin mp[i] = lo[i]; mv[i] = m; clamps++; end
          else if (n > hi[i]) begin mp[i] = hi[i]; mv[i] = -m; clamps++; end
          else mp[i] = n;
          if (mspd == ST) begin
            m = (mv[i] < 0 ? -mv[i] : mv[i]) + 1;
            if (m > 6) m = 6;
            mv[i] = mv[i] < 0 ? -m : m;
          end
        end
        if (mspd == ST) mspd = 0;
      end
    end
  end
  function automatic logic [43:0] expv();
    return {11'(mp[0]), 10'(mp[1]), 11'(mp[2]), 10'(mp[3]), mpre == TD - 1, ms == 1};
  endfunction
  wire [43:0] act = {bullet1_x, bullet1_y, bullet2_x, bullet2_y, tick, running};
  wire [41:0] start_pos = {11'd200, 10'd150, 11'd600, 10'd450};
  wire [41:0] first_step = {11'd202, 10'd152, 11'd598, 10'd452};

  task automatic test_reset();
    rst = 1; frz = 1; over = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if (act[43:2] !== start_pos) begin errors++; $display("FAIL reset_pos got=%h want=%h", act[43:2], start_pos); end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b want=0", running); end
    repeat (100) begin
      @(negedge clk);
      checks++;
      if (act[43:2] !== start_pos || running !== 1'b0) begin errors++; $display("FAIL frozen_hold got=%h want=%h0", act, start_pos); end
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL frozen_model got=%h want=%h", act, expv()); end
    end
  endtask

  task automatic test_start();
    int n = 0;
    @(posedge clk); #1 frz = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL start_running got=%b want=1", running); end
    while (!tick && n < 8) begin @(negedge clk); n++; end
    checks++;
    if (!tick) begin errors++; $display("FAIL start_tick_timeout got=0 want=1"); end
    @(negedge clk);
    checks++;
    if (act[43:2] !== first_step) begin errors++; $display("FAIL first_step got=%h want=%h", act[43:2], first_step); end
    n = 1;
    while (!tick && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (n != TD || !tick) begin errors++; $display("FAIL tick_period got=%0d want=%0d", n, TD); end
  endtask

  task automatic test_speedup();
    int n, pre_x, d, want;
    @(posedge clk); #1 frz = 1;
    @(posedge clk); #1 frz = 0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      n = 0;
      @(negedge clk);
      while (!tick && n < 8) begin @(negedge clk); n++; end
      pre_x = int'(bullet1_x);
      @(negedge clk);
      d = int'(bullet1_x) - pre_x;
      want = 2 + (k - 1) / ST;
      if (want > 6) want = 6;
      checks++;
      if (d != want) begin errors++; $display("FAIL speedup_delta tick=%0d got=%0d want=%0d", k, d, want); end
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL speedup_model got=%h want=%h", act, expv()); end
    end
  endtask

  task automatic test_bounce();
    int c0 = clamps;
    repeat (800) begin
      @(negedge clk);
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL bounce_model got=%h want=%h", act, expv()); end
      checks++;
      if (bullet1_x < 14 || bullet1_x > 750 || bullet2_x < 14 || bullet2_x > 750 ||
          bullet1_y < 48 || bullet1_y > 550 || bullet2_y < 48 || bullet2_y > 550) begin
        errors++; $display("FAIL bounce_range got=%h want=inside_playfield", act[43:2]);
      end
    end
    checks++;
    if (clamps - c0 < 1) begin errors++; $display("FAIL bounce_seen got=%0d want>0", clamps - c0); end
  endtask

  task automatic test_over();
    int n = 0;
    logic [41:0] snap;
    @(posedge clk); #1;
    while (!tick && n < 8) begin @(posedge clk); #1; n++; end
    checks++;
    if (!tick) begin errors++; $display("FAIL over_tick_timeout got=0 want=1"); end
    over = 1;
    snap = act[43:2];
    repeat (20) begin
      @(posedge clk); #1 over = 1'($urandom);
      @(negedge clk);
      checks++;
      if (act[43:2] !== snap || running !== 1'b0) begin errors++; $display("FAIL dead_hold got=%h want=%h0", act, snap); end
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL dead_model got=%h want=%h", act, expv()); end
    end
  endtask

  task automatic test_dead_restart();
    int n = 0;
    @(posedge clk); #1 frz = 1; over = 0;
    @(posedge clk); #1 frz = 0;
    @(negedge clk);
    checks++;
    if (act[43:2] !== start_pos || running !== 1'b0) begin errors++; $display("FAIL reload got=%h want=%h0", act, start_pos); end
    @(negedge clk);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL restart_running got=%b want=1", running); end
    while (!tick && n < 8) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (act[43:2] !== first_step) begin errors++; $display("FAIL restart_step got=%h want=%h", act[43:2], first_step); end
  endtask

  task automatic test_random();
    repeat (3000) begin
      @(posedge clk); #1;
      rst = $urandom_range(0, 999) == 0;
      frz = frz ? $urandom_range(0, 3) != 0 : $urandom_range(0, 149) == 0;
      over = $urandom_range(0, 59) == 0;
      @(negedge clk);
      checks++;
      if (act !== expv()) begin errors++; $display("FAIL random_model got=%h want=%h", act, expv()); end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_speedup();
    test_bounce();
    test_over();
    test_dead_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
